// File: rtl/kernel_loader.sv
// kernel_loader: streams KER_NUM coefficients into the tap chain, one tap strobe per accepted word
module kernel_loader #(
  parameter int KER_WIDTH = 16,
  parameter int KER_NUM   = 5,
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KER_WIDTH-1:0] up_ker,
  input  logic                 up_val,
  output logic                 up_rdy,
  output logic [KER_WIDTH-1:0] cfg_ker,
  output logic [KER_NUM-1:0]   cfg_val,
  output logic                 busy,
  output logic                 done,
  output logic                 loaded
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]           state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [KER_WIDTH-1:0] cfg_ker_q, cfg_ker_d;
  logic [KER_NUM-1:0]   cfg_val_q, cfg_val_d;
  logic                 busy_q, busy_d, done_q, done_d, loaded_q, loaded_d;
  logic                 accept, last;
  assign up_rdy  = state_q == LOAD;
  assign cfg_ker = cfg_ker_q;
  assign cfg_val = cfg_val_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign loaded  = loaded_q;
  always_comb begin
    accept    = up_val & up_rdy;
    // a start arriving with the final word restarts the load instead of finishing it
    last      = accept & (idx_q == IDX_WIDTH'(KER_NUM - 1)) & ~start;
    state_d   = start ? LOAD : last ? DONE : (state_q == DONE) ? IDLE : state_q;
    idx_d     = (start | last) ? '0 : accept ? idx_q + IDX_WIDTH'(1) : idx_q;
    cfg_ker_d = accept ? up_ker : cfg_ker_q;
    cfg_val_d = accept ? KER_NUM'(1) << idx_q : '0;
    busy_d    = start ? 1'b1 : last ? 1'b0 : busy_q;
    done_d    = last;
    loaded_d  = start ? 1'b0 : last ? 1'b1 : loaded_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cfg_ker_q <= '0;
      cfg_val_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cfg_ker_q <= cfg_ker_d;
      cfg_val_q <= cfg_val_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      loaded_q  <= loaded_d;
    end
  end
endmodule

// File: doc/kernel_loader.md
Name: kernel_loader

Overview:
- Writer side of the per-tap kernel configuration interface (cfg_ker / cfg_val) of the multiply_add tap chain.
- Accepts a stream of KER_NUM coefficients over a valid/ready handshake.
- Delivers each coefficient to its own tap on a shared cfg_ker bus with a one-hot cfg_val strobe.
- Reports busy, completion and kernel-loaded status to the control logic.

Parameters:
- KER_WIDTH, 16, coefficient width; matches the taps' KER_WIDTH.
- KER_NUM, 5, number of taps in the chain (>=2).
- IDX_WIDTH, 8, index counter width; must satisfy 2**IDX_WIDTH > KER_NUM.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to (re)load a complete kernel.
- up_ker  in  KER_WIDTH  incoming coefficient, signed two's complement.
- up_val  in  1  up_ker valid.
- up_rdy  out  1  loader ready to accept up_ker.
- cfg_ker  out  KER_WIDTH  coefficient broadcast to all taps.
- cfg_val  out  KER_NUM  one-hot write strobe; bit k loads tap k.
- busy  out  1  high while in LOAD.
- done  out  1  one-cycle pulse when the final coefficient has been delivered.
- loaded  out  1  level; a complete kernel is present in the taps.

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
- All outputs are registered except up_rdy, which decodes the state register.
- Reset values: state=IDLE, idx=0, cfg_ker=0, cfg_val=0, busy=0, done=0, loaded=0, up_rdy=0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - up_rdy=0; up_val is ignored.
  - start -> LOAD next cycle; idx<=0, loaded<=0, busy<=1.
- LOAD:
  - up_rdy=1.
  - An accept (up_val & up_rdy) at cycle N registers cfg_ker<=up_ker and cfg_val<=(1<<idx), both visible at N+1 for exactly one cycle. idx<=idx+1.
  - No accept in a cycle -> cfg_val=0 next cycle; cfg_ker holds its last value.
  - Accept with idx==KER_NUM-1 -> DONE next cycle; busy<=0.
- DONE: one cycle only; done=1, loaded=1, up_rdy=0; -> IDLE.
- Latency: coefficient to tap strobe is 1 cycle. Final accept to done pulse is 1 cycle, coincident with the last cfg_val strobe.
- Ordering: the k-th accepted coefficient (k=0 first) goes to tap k. Each tap is strobed exactly once per complete load.
- start in LOAD: abort and restart.
  - idx<=0; state stays LOAD.
  - Any accept in the same cycle is still strobed out, but its slot is reloaded later.
  - start wins over a simultaneous final accept: no DONE, no done pulse, loaded stays 0.
- start in DONE: state goes to LOAD; done still pulses this cycle; loaded<=0 next cycle.
- loaded:
  - Cleared on any start.
  - Set only when DONE is entered.
  - Remains 1 through IDLE until the next start or reset.
- Reset mid-LOAD: immediate return to reset values; partially written taps are not loaded.
- idx never exceeds KER_NUM-1; no wrap-around is possible, since the transition to DONE blocks further accepts.
- cfg_val is never multi-hot.
- cfg_ker passes through with no arithmetic and no width change; the sign is carried unchanged.

Test Plan:
1. Reset, then start; stream 0x0001,0x0002,0xFFFF,0x0004,0x8000 with up_val held high -> cfg_val = 00001, 00010, 00100, 01000, 10000 on consecutive cycles with the matching cfg_ker values. done is high for one cycle with the 10000 strobe; loaded=1 thereafter; busy high for 5 cycles.
2. Same load with up_val toggling 1,0,1,0,... -> cfg_val=0 on each gap cycle; strobes remain in order 0..4; done arrives 1 cycle after the 5th accept; up_rdy=1 throughout LOAD.
3. up_val=1 with up_ker=0x1234 while IDLE, no start -> up_rdy=0 and cfg_val stays 0 for 20 cycles; loaded unchanged.
4. Load 3 coefficients, then pulse start, then load 5 -> strobes 00001,00010,00100, then 00001 through 10000; a single done pulse; loaded stays 0 until that pulse.
5. Assert start in the same cycle as the 5th accept -> 10000 strobe appears; no done; state LOAD with idx=0; loaded=0.
6. Assert rst asynchronously (mid-cycle) after 2 accepts -> all outputs 0 immediately without waiting for clk; after release, IDLE with up_rdy=0.
